// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef enum logic {PORT_IF = 1'b0, PORT_LS = 1'b1} port_t;

  localparam int         STRB_W     = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] adr_lo);
    return (adr_lo & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; req/gnt bit 0 is fetch, bit 1 is load/store.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  input  logic       upd_port,
  output logic [1:0] gnt
);

  port_t last_q;

  // Pointer starts at LS so fetch wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= PORT_LS;
    end else if (upd) begin
      last_q <= port_t'(upd_port);
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (last_q == PORT_LS) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction
// at a time, with a fixed access latency, ack timeout and misalignment errors.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_req_adr,
  output logic              if_resp_valid,
  output logic [XLEN-1:0]   if_resp_data,
  output logic              if_resp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_req_we,
  input  logic [XLEN-1:0]   ls_req_adr,
  input  logic [XLEN-1:0]   ls_req_wdata,
  input  logic [STRB_W-1:0] ls_req_strobe,
  output logic              ls_resp_valid,
  output logic [XLEN-1:0]   ls_resp_data,
  output logic              ls_resp_err,
  output logic              mem_r_v,
  output logic              mem_w_v,
  output logic [XLEN-1:0]   mem_adr,
  output logic [XLEN-1:0]   mem_data,
  output logic [STRB_W-1:0] mem_strobe,
  input  logic [XLEN-1:0]   mem_resp,
  input  logic              mem_ack
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  port_t               port_q;
  logic                we_q;
  logic [XLEN-1:0]     adr_q, wdata_q, rdata_q;
  logic [STRB_W-1:0]   strobe_q;
  logic                err_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;

  logic [1:0]          gnt;
  logic                accept, acc_we, acc_misal, lat_window, timed_out;
  port_t               acc_port;
  logic [XLEN-1:0]     acc_adr, acc_wdata;
  logic [STRB_W-1:0]   acc_strobe;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({ls_req_valid, if_req_valid}),
    .en       ((state_q == IDLE) && rst_n),
    .upd      (state_q == RESP),
    .upd_port (port_q),
    .gnt      (gnt)
  );

  assign accept     = |gnt;
  assign acc_port   = gnt[1] ? PORT_LS : PORT_IF;
  assign acc_adr    = gnt[1] ? ls_req_adr : if_req_adr;
  assign acc_we     = gnt[1] & ls_req_we;
  assign acc_wdata  = gnt[1] ? ls_req_wdata : '0;
  assign acc_strobe = acc_we ? ls_req_strobe : '0;
  assign acc_misal  = is_misaligned(acc_adr[1:0]);

  // The counter is loaded with MEM_LAT in ISSUE; the answer may be sampled
  // in the WAIT cycle where it steps from 1 to 0, and every cycle after.
  assign lat_window = (lat_cnt_q == '0) || (lat_cnt_q == LAT_W'(1));
  assign timed_out  = (to_cnt_q == TO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = acc_misal ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_window && (mem_ack || timed_out)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port_q    <= PORT_IF;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      strobe_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      lat_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            port_q   <= acc_port;
            we_q     <= acc_we;
            adr_q    <= acc_adr;
            wdata_q  <= acc_wdata;
            strobe_q <= acc_strobe;
            rdata_q  <= '0;
            err_q    <= acc_misal;
          end
        end
        ISSUE: begin
          lat_cnt_q <= LAT_W'(MEM_LAT);
          to_cnt_q  <= '0;
        end
        WAIT: begin
          if (lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          if (lat_window) begin
            if (mem_ack) begin
              rdata_q <= we_q ? '0 : mem_resp;
              err_q   <= 1'b0;
            end else if (timed_out) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
        end
        default: begin
          lat_cnt_q <= '0;
          to_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign if_req_ready  = gnt[0];
  assign ls_req_ready  = gnt[1];

  assign if_resp_valid = (state_q == RESP) && (port_q == PORT_IF);
  assign ls_resp_valid = (state_q == RESP) && (port_q == PORT_LS);
  assign if_resp_err   = if_resp_valid & err_q;
  assign ls_resp_err   = ls_resp_valid & err_q;
  assign if_resp_data  = rdata_q;
  assign ls_resp_data  = rdata_q;

  assign mem_r_v    = (state_q == ISSUE) && !we_q;
  assign mem_w_v    = (state_q == ISSUE) && we_q;
  assign mem_adr    = adr_q;
  assign mem_data   = wdata_q;
  assign mem_strobe = strobe_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a small word memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int XLEN    = 32;
  localparam int MEM_LAT = 1;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req_valid, if_req_ready;
  logic [XLEN-1:0]   if_req_adr;
  logic              if_resp_valid, if_resp_err;
  logic [XLEN-1:0]   if_resp_data;
  logic              ls_req_valid, ls_req_ready, ls_req_we;
  logic [XLEN-1:0]   ls_req_adr, ls_req_wdata;
  logic [3:0]        ls_req_strobe;
  logic              ls_resp_valid, ls_resp_err;
  logic [XLEN-1:0]   ls_resp_data;
  logic              mem_r_v, mem_w_v;
  logic [XLEN-1:0]   mem_adr, mem_data, mem_resp;
  logic [3:0]        mem_strobe;
  logic              mem_ack;
  logic              ack_on;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN), .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_adr(if_req_adr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_adr(ls_req_adr), .ls_req_wdata(ls_req_wdata), .ls_req_strobe(ls_req_strobe),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
    .mem_r_v(mem_r_v), .mem_w_v(mem_w_v), .mem_adr(mem_adr), .mem_data(mem_data),
    .mem_strobe(mem_strobe), .mem_resp(mem_resp), .mem_ack(mem_ack)
  );

  // Word memory: reads answer on the edge after the issue cycle, ack is a level.
  logic [31:0] mem_arr [0:255];
  assign mem_ack = ack_on;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_resp <= '0;
    end else begin
      if (mem_w_v)
        for (int b = 0; b < 4; b++)
          if (mem_strobe[b]) mem_arr[mem_adr[9:2]][8*b +: 8] = mem_data[8*b +: 8];
      if (mem_r_v) mem_resp <= mem_arr[mem_adr[9:2]];
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        ack;
    int          exp_cycle;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_rd;
    int          exp_wr;
    logic [3:0]  exp_strobe;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    if_req_valid = 1'b0; if_req_adr = '0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_adr = '0;
    ls_req_wdata = '0; ls_req_strobe = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_if_ready"},   32'(if_req_ready),  32'd0);
    checkOutput({tag, "_ls_ready"},   32'(ls_req_ready),  32'd0);
    checkOutput({tag, "_if_rvalid"},  32'(if_resp_valid), 32'd0);
    checkOutput({tag, "_ls_rvalid"},  32'(ls_resp_valid), 32'd0);
    checkOutput({tag, "_if_err"},     32'(if_resp_err),   32'd0);
    checkOutput({tag, "_ls_err"},     32'(ls_resp_err),   32'd0);
    checkOutput({tag, "_mem_r_v"},    32'(mem_r_v),       32'd0);
    checkOutput({tag, "_mem_w_v"},    32'(mem_w_v),       32'd0);
    checkOutput({tag, "_mem_adr"},    mem_adr,            32'd0);
    checkOutput({tag, "_mem_data"},   mem_data,           32'd0);
    checkOutput({tag, "_mem_strobe"}, 32'(mem_strobe),    32'd0);
    checkOutput({tag, "_if_data"},    if_resp_data,       32'd0);
    checkOutput({tag, "_ls_data"},    ls_resp_data,       32'd0);
  endtask

  // One complete transaction: handshake at cycle 0, then watch until the response.
  task automatic applyStimulus(input vec_t v, input int idx);
    int          resp_cycle = -1;
    int          nrd = 0, nwr = 0, pulses = 0, other = 0;
    logic [31:0] got_data = '0, got_adr = '0, got_wdata = '0;
    logic        got_err = 1'b0, rdy, done = 1'b0;
    logic [3:0]  got_strobe = '0;
    logic [31:0] exp_adr;
    ack_on = v.ack;
    if (v.port) begin
      ls_req_valid = 1'b1; ls_req_we = v.we; ls_req_adr = v.adr;
      ls_req_wdata = v.wdata; ls_req_strobe = v.strobe;
    end else begin
      if_req_valid = 1'b1; if_req_adr = v.adr;
    end
    @(negedge clk);
    rdy = v.port ? ls_req_ready : if_req_ready;
    checkOutput($sformatf("v%0d_ready", idx), 32'(rdy), 32'd1);
    @(posedge clk);
    #1 clearInputs();
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (mem_r_v || mem_w_v) begin
        got_strobe = mem_strobe; got_adr = mem_adr; got_wdata = mem_data;
      end
      if (mem_r_v) nrd++;
      if (mem_w_v) nwr++;
      if (v.port ? ls_resp_valid : if_resp_valid) begin
        pulses++;
        if (resp_cycle < 0) begin
          resp_cycle = k;
          got_data = v.port ? ls_resp_data : if_resp_data;
          got_err  = v.port ? ls_resp_err : if_resp_err;
        end
      end
      if (v.port ? if_resp_valid : ls_resp_valid) other++;
      if (resp_cycle >= 0 && k > resp_cycle) done = 1'b1;
    end
    exp_adr = (v.exp_rd + v.exp_wr > 0) ? v.adr : 32'd0;
    checkOutput($sformatf("v%0d_resp_cycle", idx), 32'(resp_cycle), 32'(v.exp_cycle));
    checkOutput($sformatf("v%0d_data", idx),       got_data,         v.exp_data);
    checkOutput($sformatf("v%0d_err", idx),        32'(got_err),     32'(v.exp_err));
    checkOutput($sformatf("v%0d_pulses", idx),     32'(pulses),      32'd1);
    checkOutput($sformatf("v%0d_other_port", idx), 32'(other),       32'd0);
    checkOutput($sformatf("v%0d_mem_reads", idx),  32'(nrd),         32'(v.exp_rd));
    checkOutput($sformatf("v%0d_mem_writes", idx), 32'(nwr),         32'(v.exp_wr));
    checkOutput($sformatf("v%0d_mem_strobe", idx), 32'(got_strobe),  32'(v.exp_strobe));
    checkOutput($sformatf("v%0d_mem_adr", idx),    got_adr,          exp_adr);
    if (v.exp_wr != 0)
      checkOutput($sformatf("v%0d_mem_data", idx), got_wdata, v.wdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          grants, both_hi, if_pulses, ls_pulses, mem_v;
    logic        gnt_seq [4];
    int          hs_cycle [4];
    logic        rdy_if, rdy_ls;

    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[8'h40] = 32'hDEADBEEF;
    mem_arr[8'h08] = 32'hAABBCCDD;
    mem_arr[8'h09] = 32'h01020304;
    ack_on = 1'b1;

    //            port  we    adr        wdata         strb  ack  cyc data          err  rd wr  exp_strb
    vecs[0]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 3, 32'hDEADBEEF, 1'b0, 1, 0, 4'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h020, 32'h11223344, 4'h3, 1'b1, 3, 32'h0,        1'b0, 0, 1, 4'h3};
    vecs[2]  = '{1'b1, 1'b0, 32'h020, 32'h0,        4'hF, 1'b1, 3, 32'hAABB3344, 1'b0, 1, 0, 4'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h103, 32'h0,        4'h0, 1'b1, 1, 32'h0,        1'b1, 0, 0, 4'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h102, 32'h0,        4'h0, 1'b1, 1, 32'h0,        1'b1, 0, 0, 4'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 1'b0, 19, 32'h0,       1'b1, 1, 0, 4'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h024, 32'hCAFEF00D, 4'hC, 1'b1, 3, 32'h0,        1'b0, 0, 1, 4'hC};
    vecs[7]  = '{1'b0, 1'b0, 32'h024, 32'h0,        4'h0, 1'b1, 3, 32'hCAFE0304, 1'b0, 1, 0, 4'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h022, 32'hFFFFFFFF, 4'hF, 1'b1, 1, 32'h0,        1'b1, 0, 0, 4'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h020, 32'h0,        4'h0, 1'b1, 3, 32'hAABB3344, 1'b0, 1, 0, 4'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 3, 32'hDEADBEEF, 1'b0, 1, 0, 4'h0};

    doReset();
    @(negedge clk);
    checkResetValues("reset");

    // Both ports valid continuously: expect IF, LS, IF, LS, each 4 cycles apart.
    @(posedge clk);
    #1;
    grants = 0; both_hi = 0;
    for (int i = 0; i < 4; i++) begin gnt_seq[i] = 1'b0; hs_cycle[i] = 0; end
    if_req_valid = 1'b1; if_req_adr = 32'h100;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_adr = 32'h020; ls_req_strobe = 4'h0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      @(negedge clk);
      if (if_req_ready && ls_req_ready) both_hi++;
      if (if_req_ready) begin
        gnt_seq[grants] = 1'b0; hs_cycle[grants] = c; grants++;
      end else if (ls_req_ready) begin
        gnt_seq[grants] = 1'b1; hs_cycle[grants] = c; grants++;
      end
    end
    @(posedge clk);
    #1 clearInputs();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rr_grants", 32'(grants), 32'd4);
    checkOutput("rr_both_ready", 32'(both_hi), 32'd0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rr_grant%0d", i), 32'(gnt_seq[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("rr_spacing%0d", i), 32'(hs_cycle[i] - hs_cycle[i-1]), 32'd4);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // Reset while a fetch sits in WAIT (ack held low so it cannot finish).
    ack_on = 1'b0;
    if_req_valid = 1'b1; if_req_adr = 32'h100;
    @(negedge clk);
    checkOutput("rst_wait_ready", 32'(if_req_ready), 32'd1);
    @(posedge clk);
    #1 clearInputs();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ack_on = 1'b1;
    @(negedge clk);
    checkResetValues("rst_wait");
    if_pulses = 0; ls_pulses = 0; mem_v = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (if_resp_valid) if_pulses++;
      if (ls_resp_valid) ls_pulses++;
      if (mem_r_v || mem_w_v) mem_v++;
    end
    checkOutput("rst_wait_no_resp", 32'(if_pulses + ls_pulses), 32'd0);
    checkOutput("rst_wait_no_mem",  32'(mem_v), 32'd0);

    @(posedge clk);
    #1;
    if_req_valid = 1'b1; if_req_adr = 32'h100;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_adr = 32'h020;
    @(negedge clk);
    rdy_if = if_req_ready; rdy_ls = ls_req_ready;
    checkOutput("rst_prio_if_ready", 32'(rdy_if), 32'd1);
    checkOutput("rst_prio_ls_ready", 32'(rdy_ls), 32'd0);
    @(posedge clk);
    #1 clearInputs();
    if_pulses = 0; ls_pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_resp_valid) begin
        if_pulses++;
        checkOutput("rst_prio_if_data", if_resp_data, 32'hDEADBEEF);
      end
      if (ls_resp_valid) ls_pulses++;
    end
    checkOutput("rst_prio_if_pulses", 32'(if_pulses), 32'd1);
    checkOutput("rst_prio_ls_pulses", 32'(ls_pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
